// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx_pkg
// Purpose  : Shared state encoding and serial line levels for fifo_uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Per-bit cycle counter; tick marks the last cycle of a serial bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops words from a synchronous FIFO and sends them as serial frames.
//            FIFO_UART_TX_PARITY_EN adds an even-parity bit after the data.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int W            = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_en,
    input  logic         fifo_empty,
    input  logic [W-1:0] fifo_data,
    output logic         fifo_rd_en,
    output logic         tx,
    output logic         busy,
    output logic         frame_done
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] C_LAST_BIT = BW'(W - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [W-1:0]  r_shift;
    logic [BW-1:0] r_bit_idx;
    logic          w_tick;
    logic          w_clear;
    logic          w_pop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic          r_parity;
`endif

    // Counter held at zero outside a frame so START always gets a full bit.
    assign w_clear    = (r_state == IDLE) || (r_state == WAIT);
    assign w_pop      = (r_state == IDLE) && tx_en && !fifo_empty;
    assign fifo_rd_en = w_pop;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (r_state == WAIT) begin
            r_shift   <= fifo_data;
            r_bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= ^fifo_data;
`endif
        end else if ((r_state == DATA) && w_tick) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:   if (w_pop)  w_next_state = WAIT;
            WAIT:               w_next_state = START;
            START:  if (w_tick) w_next_state = DATA;
            DATA: begin
                if (w_tick && (r_bit_idx == C_LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
            PARITY: if (w_tick) w_next_state = STOP;
            STOP:   if (w_tick) w_next_state = IDLE;
            default:            w_next_state = IDLE;
        endcase
    end

    always_comb begin
        tx         = IDLE_LEVEL;
        busy       = (r_state != IDLE);
        frame_done = (r_state == STOP) && w_tick;
        case (r_state)
            START:  tx = START_BIT;
            DATA:   tx = r_shift[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx = r_parity;
`endif
            STOP:   tx = STOP_BIT;
            default: tx = IDLE_LEVEL;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Directed bench for fifo_uart_tx with a simple FIFO read-side model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int W            = 4;
    localparam int CLKS_PER_BIT = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = W + 3;
    localparam logic [NB-1:0] F_A = 7'b1010100;
    localparam logic [NB-1:0] F_7 = 7'b1101110;
    localparam logic [NB-1:0] F_3 = 7'b1000110;
    localparam logic [NB-1:0] F_C = 7'b1011000;
    localparam logic [NB-1:0] F_9 = 7'b1010010;
`else
    localparam int NB = W + 2;
    localparam logic [NB-1:0] F_A = 6'b110100;
    localparam logic [NB-1:0] F_7 = 6'b101110;
    localparam logic [NB-1:0] F_3 = 6'b100110;
    localparam logic [NB-1:0] F_C = 6'b111000;
    localparam logic [NB-1:0] F_9 = 6'b110010;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_en;
    logic         fifo_empty;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;
    logic         frame_done;

    logic [W-1:0] mem [0:255];
    logic [7:0]   wr_ptr = 8'd0;
    logic [7:0]   rd_ptr = 8'd0;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int bad_pop_cnt = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .W            (W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Registered-output FIFO read side: data valid the cycle after the pop.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    always @(posedge clk) begin
        if (fifo_rd_en)               pop_cnt++;
        if (frame_done)               done_cnt++;
        if (fifo_rd_en && fifo_empty) bad_pop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic [W-1:0] word);
        mem[wr_ptr] = word;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [W-1:0] word);
        logic [NB-1:0] b;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < W; i++) b[i+1] = word[i];
`ifdef FIFO_UART_TX_PARITY_EN
        b[W+1] = ^word;
`endif
        return b;
    endfunction

    // Called on a falling edge; waits for the pop, then checks every cycle of the frame.
    task automatic expect_frame(input logic [NB-1:0] bits, input string tag,
                                input int exp_wait, input bit drop_en);
        int n;
        n = 0;
        #1;
        while (!fifo_rd_en && n < 200) begin
            @(negedge clk);
            n++;
            #1;
        end
        if (!fifo_rd_en) begin
            check({tag, "_pop_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (exp_wait >= 0) check({tag, "_pop_wait"}, n, exp_wait);
        check({tag, "_idle_tx"}, tx, 1'b1);
        @(negedge clk);
        check({tag, "_rd_pulse"}, fifo_rd_en, 1'b0);
        check({tag, "_wait_tx"}, tx, 1'b1);
        check({tag, "_wait_busy"}, busy, 1'b1);
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < CLKS_PER_BIT; c++) begin
                @(negedge clk);
                if (drop_en && k == 2 && c == 0) tx_en = 1'b0;
                check({tag, "_tx"}, tx, bits[k]);
                check({tag, "_busy"}, busy, 1'b1);
                check({tag, "_no_pop"}, fifo_rd_en, 1'b0);
                check({tag, "_frame_done"}, frame_done,
                      (k == NB - 1 && c == CLKS_PER_BIT - 1) ? 1'b1 : 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] words [16];
        int viol;
        int pop_base;
        int done_base;
        int n;

        // Reset and idle with an empty FIFO
        rst   = 1'b0;
        tx_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        rst   = 1'b1;
        tx_en = 1'b1;
        viol  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) viol++;
        end
        check("idle_violations", viol, 0);

        // Single word 4'hA
        push(4'hA);
        expect_frame(F_A, "single_a", 0, 1'b0);
        @(negedge clk);
        check("single_empty", fifo_empty, 1'b1);
        check("single_idle_busy", busy, 1'b0);
        check("single_idle_tx", tx, 1'b1);

        // Back-to-back 4'hA then 4'h7
        repeat (3) @(negedge clk);
        push(4'hA);
        push(4'h7);
        expect_frame(F_A, "b2b_a", 0, 1'b0);
        expect_frame(F_7, "b2b_7", 1, 1'b0);

        // Burst of 16 words from a full FIFO
        repeat (4) @(negedge clk);
        tx_en     = 1'b0;
        pop_base  = pop_cnt;
        done_base = done_cnt;
        for (int i = 0; i < 16; i++) begin
            words[i] = W'($urandom);
            push(words[i]);
        end
        @(negedge clk);
        tx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_frame(frame_bits(words[i]), "burst", (i == 0) ? 0 : 1, 1'b0);
        end
        repeat (20) @(negedge clk);
        check("burst_pops", pop_cnt - pop_base, 16);
        check("burst_frames", done_cnt - done_base, 16);
        check("burst_bad_pops", bad_pop_cnt, 0);
        check("burst_empty", fifo_empty, 1'b1);

        // Flow control: tx_en dropped mid-frame
        push(4'h3);
        push(4'hC);
        expect_frame(F_3, "flow_3", 0, 1'b1);
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) viol++;
        end
        check("flow_hold_violations", viol, 0);
        check("flow_not_empty", fifo_empty, 1'b0);
        tx_en = 1'b1;
        expect_frame(F_C, "flow_c", 0, 1'b0);

        // Reset during data bit 2 of 4'h5
        repeat (3) @(negedge clk);
        push(4'h5);
        push(4'h9);
        n = 0;
        #1;
        while (!fifo_rd_en && n < 200) begin
            @(negedge clk);
            n++;
            #1;
        end
        check("mid_rst_pop_seen", fifo_rd_en, 1'b1);
        repeat (15) @(negedge clk);
        check("mid_rst_bit2_tx", tx, 1'b1);
        check("mid_rst_busy_before", busy, 1'b1);
        rst   = 1'b0;
        tx_en = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        tx_en = 1'b1;
        expect_frame(F_9, "after_rst_9", 0, 1'b0);
        repeat (5) @(negedge clk);
        check("final_empty", fifo_empty, 1'b1);
        check("final_bad_pops", bad_pop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side master for the team's synchronous FIFO (clk, rst, rd_en, wr_en, data_in, data_out, FULL, EMPTY).
- Pops one word at a time whenever the FIFO is non-empty and serializes it as an asynchronous serial frame: start bit, W data bits LSB first, optional parity, stop bit.
- Sits between the FIFO data_out/EMPTY pins and an off-chip serial line. It is the consumer end of the FIFO interface the FIFO bench drives from the writer side.

Parameters:
- W, 4, data word width; must match the FIFO width.
- CLKS_PER_BIT, 4, clk cycles per serial bit; minimum 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- tx_en  in  1  permission to start new frames.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_data  in  W  FIFO data_out.
- fifo_rd_en  out  1  FIFO rd_en; a one-cycle pulse per word.
- tx  out  1  serial line; idles high.
- busy  out  1  high from the pop until the stop bit completes.
- frame_done  out  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- FIFO contract: data_out is registered and valid in the cycle after rd_en is sampled high with EMPTY low.
- fifo_rd_en is combinational and equals (state==IDLE && tx_en && !fifo_empty). It is never asserted in any other state, so the block never pops an empty FIFO and never pops twice per frame.
- State machine:
  - IDLE: tx=1. If the pop condition holds, go to WAIT.
  - WAIT: lasts one cycle. Load fifo_data into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0]. Each bit lasts CLKS_PER_BIT cycles; shift right at each bit end. After W bits go to PARITY if the parity feature is compiled in, otherwise go to STOP.
  - PARITY: tx=^word for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. frame_done pulses in the final cycle, then go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1. Bit-end tick is asserted at count CLKS_PER_BIT-1, then the counter wraps to 0.
- busy is high in WAIT, START, DATA, PARITY and STOP.
- Latency: tx falls 2 cycles after the cycle in which fifo_rd_en is high.
- Frame length (START through STOP) is (W+2)*CLKS_PER_BIT cycles, or (W+3)*CLKS_PER_BIT with parity.
- Back-to-back frames: STOP returns to IDLE, and IDLE may pop in that same cycle. The inter-frame gap is therefore 2 idle-high cycles (IDLE plus WAIT) after the stop bit.
- tx_en deasserted mid-frame: the current frame completes; no new pop occurs.
- fifo_empty rising mid-frame: ignored; it is only sampled in IDLE.
- Reset mid-frame: tx returns to 1 immediately and the word in flight is discarded. If rst asserts in the same cycle as a pop, the popped word is lost; this is accepted.
- Outputs tx, busy and frame_done are registered or derived from state only, so tx is glitch-free.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: the PARITY state is present and sends the even-parity bit (XOR of the word) after the data bits. Frame length is (W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state; DATA goes directly to STOP. Frame length is (W+2)*CLKS_PER_BIT.

Decomposition:
- Package fifo_uart_tx_pkg:
  - State enum typedef: IDLE, WAIT, START, DATA, PARITY, STOP.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- Sub-module uart_baud_tick: the counter with a clear input, producing the bit-end tick. Parameterized by CLKS_PER_BIT.

Test Plan (W=4, CLKS_PER_BIT=4):
- Reset and idle: hold rst=0 for 3 cycles, then release with fifo_empty=1 and tx_en=1 for 50 cycles -> tx=1, fifo_rd_en never asserted, busy=0.
- Single word, no parity: the FIFO holds 4'hA.
  - fifo_rd_en pulses high for exactly 1 cycle; tx goes low 2 cycles later.
  - tx sequence, 4 cycles each: 0,0,1,0,1,1.
  - frame_done pulses at cycle 24 of the frame; the FIFO becomes empty.
- Parity build, 4'hA then 4'h7:
  - First frame: 0,0,1,0,1,0(parity),1.
  - Second frame: 0,1,1,1,0,1(parity),1.
  - Exactly 2 idle-high cycles between the frames; each frame is 28 cycles.
- Burst of 16 words from a full FIFO: fill with $random values and let it drain.
  - Exactly 16 fifo_rd_en pulses and 16 frame_done pulses.
  - The decoded serial words match the write order.
  - No pop after EMPTY rises.
- Flow control: drop tx_en in the DATA state of frame 1 -> frame 1 completes; no pop while tx_en=0. Raise tx_en -> a pop occurs in the next IDLE cycle.
- Reset mid-frame: assert rst during bit 2 of 4'h5 -> tx=1 asynchronously and busy=0. After release, the next pop sends the following FIFO word; 4'h5 is not retransmitted.
